// File: rtl/sdam_gen2.sv
// Serial address/data deserializer: frames sampled on scl are framing-checked
// and good frames are pushed into a DEPTH-entry FIFO drained by valid/ready.
//
// state  | meaning
// S_IDLE | waiting for a start bit (sda low)
// S_ADDR | shifting in ADDR_W address bits
// S_DATA | shifting in DATA_W data bits
// S_PAR  | sampling the even-parity bit
// S_STOP | sampling the stop bit; push, frame_err or ovf decided here
module sdam_gen2 #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 4,
    parameter int PARITY_EN = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic                         scl,
    input  logic                         reset,
    input  logic                         sda,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [DATA_W-1:0]            out_data,
    output logic                         frame_err,
    output logic                         ovf,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_W + DATA_W;

    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_TOP  = ADDR_ONE << (ADDR_W - 1);
    localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);
    localparam logic [DATA_W-1:0] DATA_TOP  = DATA_ONE << (DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               par_q, par_d;
    logic               frame_err_q, frame_err_d;
    logic               ovf_q, ovf_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [ENT_W-1:0]   mem_d [DEPTH];

    logic               push;
    logic               pop;
    logic               writable;
    logic               good;
    logic [ADDR_W-1:0]  addr_bit;
    logic [DATA_W-1:0]  data_bit;

    assign pop      = (level_q != '0) && out_ready;
    assign writable = (level_q != LVL_FULL) || pop;

    // One-hot mask selecting where the current serial bit lands in each field.
    assign addr_bit = (MSB_FIRST != 0) ? (ADDR_TOP >> cnt_q) : (ADDR_ONE << cnt_q);
    assign data_bit = (MSB_FIRST != 0) ? (DATA_TOP >> cnt_q) : (DATA_ONE << cnt_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        par_d       = par_q;
        frame_err_d = 1'b0;
        ovf_d       = 1'b0;
        push        = 1'b0;
        good        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!sda) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            S_ADDR: begin
                addr_d = sda ? (addr_q | addr_bit) : (addr_q & ~addr_bit);
                par_d  = par_q ^ sda;
                if (cnt_q == ADDR_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                data_d = sda ? (data_q | data_bit) : (data_q & ~data_bit);
                par_d  = par_q ^ sda;
                if (cnt_q == DATA_LAST) begin
                    state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PAR: begin
                par_d   = par_q ^ sda;
                state_d = S_STOP;
                cnt_d   = '0;
            end
            S_STOP: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                good    = sda && ((PARITY_EN == 0) || !par_q);
                if (!good) begin
                    frame_err_d = 1'b1;
                end else if (writable) begin
                    push = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = {addr_q, data_q};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge scl or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            par_q       <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            par_q       <= par_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            mem_q       <= mem_d;
        end
    end

    assign out_valid             = (level_q != '0);
    assign {out_addr, out_data}  = mem_q[rd_ptr_q];
    assign frame_err             = frame_err_q;
    assign ovf                   = ovf_q;
    assign level                 = level_q;

endmodule

// File: tb/tb_sdam_gen2.sv
// Directed bench for sdam_gen2: default-parameter instance plus an MSB-first,
// 4/8-bit, no-parity instance sharing the clock and reset.
module tb_sdam_gen2;

    logic        scl = 1'b0;
    logic        reset = 1'b1;
    logic        sda = 1'b1;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_addr;
    logic [15:0] out_data;
    logic        frame_err;
    logic        ovf;
    logic [2:0]  level;

    logic        sda2 = 1'b1;
    logic        out_ready2 = 1'b0;
    logic        out_valid2;
    logic [3:0]  out_addr2;
    logic [7:0]  out_data2;
    logic        frame_err2;
    logic        ovf2;
    logic [2:0]  level2;

    int errors = 0;
    int checks = 0;

    always #5 scl = ~scl;

    sdam_gen2 dut (
        .scl(scl), .reset(reset), .sda(sda), .out_ready(out_ready),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
        .frame_err(frame_err), .ovf(ovf), .level(level)
    );

    sdam_gen2 #(.ADDR_W(4), .DATA_W(8), .DEPTH(4), .PARITY_EN(0), .MSB_FIRST(1)) dut2 (
        .scl(scl), .reset(reset), .sda(sda2), .out_ready(out_ready2),
        .out_valid(out_valid2), .out_addr(out_addr2), .out_data(out_data2),
        .frame_err(frame_err2), .ovf(ovf2), .level(level2)
    );

    // Drives one LSB-first frame on the default instance; returns 1 time unit
    // after the stop-bit edge so outputs of that edge can be checked.
    task automatic send_frame(input logic [7:0] a, input logic [15:0] d,
                              input logic bad_par, input logic stop_b,
                              input logic rdy_stop);
        logic p;
        p = (^a) ^ (^d) ^ bad_par;
        @(negedge scl) sda = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge scl) sda = a[i];
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge scl) sda = d[i];
        end
        @(negedge scl) sda = p;
        @(negedge scl);
        sda = stop_b;
        if (rdy_stop) out_ready = 1'b1;
        @(posedge scl);
        #1;
        sda = 1'b1;
        if (rdy_stop) out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (out_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h want=00", out_addr); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h want=0000", out_data); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", level); end
        checks++; if ({frame_err, ovf} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b want=00", {frame_err, ovf}); end
        @(negedge scl) reset = 1'b0;
        repeat (3) @(negedge scl);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_hold_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_good_frame();
        out_ready = 1'b0;
        send_frame(8'hA5, 16'h1234, 1'b0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL good_valid got=%b want=1", out_valid); end
        checks++; if (out_addr !== 8'hA5) begin errors++; $display("FAIL good_addr got=%h want=a5", out_addr); end
        checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL good_data got=%h want=1234", out_data); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL good_level got=%0d want=1", level); end
        checks++; if ({frame_err, ovf} !== 2'b00) begin errors++; $display("FAIL good_pulses got=%b want=00", {frame_err, ovf}); end
        @(negedge scl) out_ready = 1'b1;
        @(negedge scl) out_ready = 1'b0;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL good_drain_level got=%0d want=0", level); end
    endtask

    task automatic test_frame_errors();
        send_frame(8'hA5, 16'h1234, 1'b1, 1'b1, 1'b0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL par_err_pulse got=%b want=1", frame_err); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL par_err_level got=%0d want=0", level); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL par_err_ovf got=%b want=0", ovf); end
        @(posedge scl); #1;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL par_err_width got=%b want=0", frame_err); end
        send_frame(8'hA5, 16'h1234, 1'b0, 1'b0, 1'b0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL stop_err_pulse got=%b want=1", frame_err); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL stop_err_level got=%0d want=0", level); end
        @(posedge scl); #1;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL stop_err_width got=%b want=0", frame_err); end
    endtask

    task automatic test_back_to_back_ovf();
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'h10 + 8'(k), 16'(k), 1'b0, 1'b1, 1'b0);
            if (k <= 4) begin
                checks++; if (level !== 3'(k)) begin errors++; $display("FAIL b2b_level k=%0d got=%0d want=%0d", k, level, k); end
                checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_no_ovf k=%0d got=%b want=0", k, ovf); end
            end else begin
                checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL b2b_ovf got=%b want=1", ovf); end
                checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_full_level got=%0d want=4", level); end
            end
        end
        @(posedge scl); #1;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf_width got=%b want=0", ovf); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge scl) out_ready = 1'b1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pop_valid k=%0d got=%b want=1", k, out_valid); end
            checks++; if (out_data !== 16'(k)) begin errors++; $display("FAIL pop_data k=%0d got=%h want=%h", k, out_data, 16'(k)); end
            checks++; if (out_addr !== 8'h10 + 8'(k)) begin errors++; $display("FAIL pop_addr k=%0d got=%h want=%h", k, out_addr, 8'h10 + 8'(k)); end
        end
        @(negedge scl) out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_empty got=%b want=0", out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL pop_empty_level got=%0d want=0", level); end
    endtask

    task automatic test_full_with_pop();
        logic [15:0] exp_q [4];
        exp_q = '{16'h0002, 16'h0003, 16'h0004, 16'hBEEF};
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send_frame(8'h20 + 8'(k), 16'(k), 1'b0, 1'b1, 1'b0);
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_pre_level got=%0d want=4", level); end
        send_frame(8'h55, 16'hBEEF, 1'b0, 1'b1, 1'b1);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_pop_ovf got=%b want=0", ovf); end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_pop_level got=%0d want=4", level); end
        for (int k = 0; k < 4; k++) begin
            @(negedge scl) out_ready = 1'b1;
            checks++; if (out_data !== exp_q[k]) begin errors++; $display("FAIL full_pop_data k=%0d got=%h want=%h", k, out_data, exp_q[k]); end
        end
        @(negedge scl) out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_pop_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_msb_first();
        logic [13:0] v;
        v = 14'b0_1010_11000011_1;
        for (int i = 13; i >= 0; i--) begin
            @(negedge scl) sda2 = v[i];
        end
        @(posedge scl); #1;
        sda2 = 1'b1;
        checks++; if (out_valid2 !== 1'b1) begin errors++; $display("FAIL msb_valid got=%b want=1", out_valid2); end
        checks++; if (out_addr2 !== 4'hA) begin errors++; $display("FAIL msb_addr got=%h want=a", out_addr2); end
        checks++; if (out_data2 !== 8'hC3) begin errors++; $display("FAIL msb_data got=%h want=c3", out_data2); end
        checks++; if (level2 !== 3'd1) begin errors++; $display("FAIL msb_level got=%0d want=1", level2); end
        checks++; if (frame_err2 !== 1'b0) begin errors++; $display("FAIL msb_err got=%b want=0", frame_err2); end
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b0;
        send_frame(8'h77, 16'h0F0F, 1'b0, 1'b1, 1'b0);
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL mid_pre_level got=%0d want=1", level); end
        @(negedge scl) sda = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge scl) sda = 1'(i & 1);
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
        checks++; if (out_addr !== 8'h00) begin errors++; $display("FAIL mid_rst_addr got=%h want=00", out_addr); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL mid_rst_data got=%h want=0000", out_data); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_rst_level got=%0d want=0", level); end
        checks++; if (level2 !== 3'd0) begin errors++; $display("FAIL mid_rst_level2 got=%0d want=0", level2); end
        @(negedge scl);
        sda = 1'b1;
        reset = 1'b0;
        @(negedge scl);
        send_frame(8'h3C, 16'hCAFE, 1'b0, 1'b1, 1'b0);
        checks++; if (out_addr !== 8'h3C) begin errors++; $display("FAIL post_rst_addr got=%h want=3c", out_addr); end
        checks++; if (out_data !== 16'hCAFE) begin errors++; $display("FAIL post_rst_data got=%h want=cafe", out_data); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL post_rst_level got=%0d want=1", level); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL post_rst_err got=%b want=0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_frame_errors();
        test_back_to_back_ovf();
        test_full_with_pop();
        test_msb_first();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
